alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk input 1 rising-edge clock; resetn input 1 async active-low reset.
REQ-002 SHALL have in_valid input 1: upstream instruction valid; in_ready output 1: stage can accept.
REQ-003 SHALL have in_inst input 32: MIPS instruction word; rs_data input 32: GPR[rs] value; rt_data input 32: GPR[rt] value (both sampled with in_inst).
REQ-004 SHALL have flush input 1: discard held and incoming work.
REQ-005 SHALL have out_valid output 1; out_ready input 1: downstream ALU stage handshake.
REQ-006 SHALL have out_alu_control output 12: one-hot op, bit11..0 = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui.
REQ-007 SHALL have out_alu_src1 output 32, out_alu_src2 output 32, out_dest output 5 (write register), out_wen output 1 (register write enable).

Function
REQ-008 SHALL be a single registered stage: accept when in_valid & in_ready, outputs updated on that clk edge, latency 1 cycle.
REQ-009 in_ready SHALL equal ~flush & (~out_valid | out_ready); back-to-back acceptance at full rate when out_ready=1.
REQ-010 While out_valid & ~out_ready, all out_* SHALL hold stable.
REQ-011 out_valid SHALL set on acceptance, clear on out_valid & out_ready without new acceptance, clear on flush (flush wins over all).
REQ-012 R-type (opcode 0x00) funct decode: 0x20/0x21 add; 0x22/0x23 sub; 0x2A slt; 0x2B sltu; 0x24 and; 0x27 nor; 0x25 or; 0x26 xor; 0x00/0x04 sll; 0x02/0x06 srl; 0x03/0x07 sra; src1=rs_data, src2=rt_data, dest=rd.
REQ-013 Immediate shifts (funct 0x00/0x02/0x03) SHALL drive src1={27'b0,sa}; variable shifts drive src1=rs_data; src2=rt_data (value to shift).
REQ-014 I-type: 0x08/0x09 add, 0x0A slt, 0x0B sltu with src2=sign-extended imm; 0x0C and, 0x0D or, 0x0E xor with src2=zero-extended imm; src1=rs_data, dest=rt.
REQ-015 LUI (opcode 0x0F) SHALL drive lui, src1=0, src2={16'b0,imm}, dest=rt.
REQ-016 ADD/SUB/ADDI SHALL decode identically to unsigned forms; no overflow detection.
REQ-017 out_wen SHALL be 1 only for legal instructions with dest != 0.
REQ-018 Any other opcode/funct (illegal) SHALL still be accepted and output with alu_control=0, src1=src2=0, dest=0, wen=0.
REQ-019 out_alu_control SHALL be exactly one-hot for legal instructions, all-zero otherwise.

Reset
REQ-020 On resetn low, asynchronously: out_valid=0, out_alu_control=0, out_alu_src1=0, out_alu_src2=0, out_dest=0, out_wen=0 (out_ri=0 if present); in-flight instruction lost.
REQ-021 in_ready SHALL be 1 after reset deassertion with flush low.

Configuration
REQ-022 Macro ALU_DEC_RI_EN defined: adds output out_ri 1 (registered with other outputs), =1 exactly for illegal instructions per REQ-018.
REQ-023 Macro undefined: no out_ri port; illegal instructions pass as silent bubbles (REQ-018); all other behaviour identical.

Structure
REQ-024 Shared package alu_pkg SHALL hold one-hot bit indices/width (12), opcode constants and funct constants.
REQ-025 Combinational decode SHALL be sub-module alu_inst_dec (inst, rs_data, rt_data in; control, src1, src2, dest, wen, ri out); alu_decode_stage holds handshake and output register.

Verification
REQ-026 in_inst=0x00221821 (addu $3,$1,$2), rs_data=5, rt_data=7 -> next cycle out_valid=1, control=0x800, src1=5, src2=7, dest=3, wen=1.
REQ-027 in_inst=0x000220C3 (sra $4,$2,3), rt_data=0x80000000 -> control=0x002, src1=3, src2=0x80000000, dest=4.
REQ-028 in_inst=0x2405FFFF (addiu $5,$0,-1) -> control=0x800, src2=0xFFFFFFFF; in_inst=0x3005FFFF (andi) -> control=0x080, src2=0x0000FFFF.
REQ-029 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> held word consumed, next accepted same edge.
REQ-030 flush=1 with out_valid=1 and in_valid=1 -> in_ready=0, out_valid=0 next cycle, no instruction emitted.
REQ-031 in_inst=0xFC000000 -> control=0, wen=0, out_ri=1 with ALU_DEC_RI_EN; resetn low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU decode stage: one-hot ALU operation
// bit positions, their one-hot codes, and MIPS opcode/funct encodings.
package alu_pkg;

  localparam int ALU_OP_W = 12;

  // One-hot bit positions of out_alu_control
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [ALU_OP_W-1:0] CTRL_ADD  = ALU_OP_W'(1 << ALU_ADD);
  localparam logic [ALU_OP_W-1:0] CTRL_SUB  = ALU_OP_W'(1 << ALU_SUB);
  localparam logic [ALU_OP_W-1:0] CTRL_SLT  = ALU_OP_W'(1 << ALU_SLT);
  localparam logic [ALU_OP_W-1:0] CTRL_SLTU = ALU_OP_W'(1 << ALU_SLTU);
  localparam logic [ALU_OP_W-1:0] CTRL_AND  = ALU_OP_W'(1 << ALU_AND);
  localparam logic [ALU_OP_W-1:0] CTRL_NOR  = ALU_OP_W'(1 << ALU_NOR);
  localparam logic [ALU_OP_W-1:0] CTRL_OR   = ALU_OP_W'(1 << ALU_OR);
  localparam logic [ALU_OP_W-1:0] CTRL_XOR  = ALU_OP_W'(1 << ALU_XOR);
  localparam logic [ALU_OP_W-1:0] CTRL_SLL  = ALU_OP_W'(1 << ALU_SLL);
  localparam logic [ALU_OP_W-1:0] CTRL_SRL  = ALU_OP_W'(1 << ALU_SRL);
  localparam logic [ALU_OP_W-1:0] CTRL_SRA  = ALU_OP_W'(1 << ALU_SRA);
  localparam logic [ALU_OP_W-1:0] CTRL_LUI  = ALU_OP_W'(1 << ALU_LUI);

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  // SPECIAL funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

endpackage

// File: rtl/alu_inst_dec.sv
// Combinational MIPS ALU-instruction decoder. Produces one-hot ALU control,
// operand values, destination register and write enable. Unrecognised
// encodings decode to an all-zero bubble with ri=1.
module alu_inst_dec
  import alu_pkg::*;
(
  input  logic [31:0]         inst,
  input  logic [31:0]         rs_data,
  input  logic [31:0]         rt_data,
  output logic [ALU_OP_W-1:0] control,
  output logic [31:0]         src1,
  output logic [31:0]         src2,
  output logic [4:0]          dest,
  output logic                wen,
  output logic                ri
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  sa_f;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        legal;
  logic        unused_rs_field;

  assign opcode   = inst[31:26];
  assign rt_f     = inst[20:16];
  assign rd_f     = inst[15:11];
  assign sa_f     = inst[10:6];
  assign funct    = inst[5:0];
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};
  // The rs field is not needed: the register file already supplies rs_data.
  assign unused_rs_field = ^inst[25:21];

  // Decode opcode/funct into control and operands; anything unmatched stays zero
  always_comb begin
    control = '0;
    src1    = '0;
    src2    = '0;
    dest    = '0;
    legal   = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        legal = 1'b1;
        src1  = rs_data;
        src2  = rt_data;
        dest  = rd_f;
        case (funct)
          F_ADD, F_ADDU: control = CTRL_ADD;
          F_SUB, F_SUBU: control = CTRL_SUB;
          F_SLT:         control = CTRL_SLT;
          F_SLTU:        control = CTRL_SLTU;
          F_AND:         control = CTRL_AND;
          F_NOR:         control = CTRL_NOR;
          F_OR:          control = CTRL_OR;
          F_XOR:         control = CTRL_XOR;
          F_SLLV:        control = CTRL_SLL;
          F_SRLV:        control = CTRL_SRL;
          F_SRAV:        control = CTRL_SRA;
          // Immediate shifts take the shift amount from the sa field
          F_SLL: begin control = CTRL_SLL; src1 = {27'b0, sa_f}; end
          F_SRL: begin control = CTRL_SRL; src1 = {27'b0, sa_f}; end
          F_SRA: begin control = CTRL_SRA; src1 = {27'b0, sa_f}; end
          default: begin
            legal = 1'b0;
            src1  = '0;
            src2  = '0;
            dest  = '0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin legal = 1'b1; control = CTRL_ADD;  src1 = rs_data; src2 = imm_sext; dest = rt_f; end
      OP_SLTI:           begin legal = 1'b1; control = CTRL_SLT;  src1 = rs_data; src2 = imm_sext; dest = rt_f; end
      OP_SLTIU:          begin legal = 1'b1; control = CTRL_SLTU; src1 = rs_data; src2 = imm_sext; dest = rt_f; end
      OP_ANDI:           begin legal = 1'b1; control = CTRL_AND;  src1 = rs_data; src2 = imm_zext; dest = rt_f; end
      OP_ORI:            begin legal = 1'b1; control = CTRL_OR;   src1 = rs_data; src2 = imm_zext; dest = rt_f; end
      OP_XORI:           begin legal = 1'b1; control = CTRL_XOR;  src1 = rs_data; src2 = imm_zext; dest = rt_f; end
      OP_LUI:            begin legal = 1'b1; control = CTRL_LUI;  src1 = '0;      src2 = imm_zext; dest = rt_f; end
      default: ;
    endcase
  end

  assign wen = legal & (dest != 5'd0);
  assign ri  = ~legal;

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage with valid/ready handshake and flush.
// Optional feature: define ALU_DEC_RI_EN to add the out_ri
// (reserved-instruction) output; otherwise illegal instructions pass as
// silent bubbles.
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [31:0]         rs_data,
  input  logic [31:0]         rt_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] out_alu_control,
  output logic [31:0]         out_alu_src1,
  output logic [31:0]         out_alu_src2,
  output logic [4:0]          out_dest,
`ifdef ALU_DEC_RI_EN
  output logic                out_ri,
`endif
  output logic                out_wen
);

  logic [ALU_OP_W-1:0] ctrl_p0;
  logic [31:0]         src1_p0;
  logic [31:0]         src2_p0;
  logic [4:0]          dest_p0;
  logic                wen_p0;
  logic                ri_p0;
  logic                accept_p0;

  logic                vld_p1;
  logic [ALU_OP_W-1:0] ctrl_p1;
  logic [31:0]         src1_p1;
  logic [31:0]         src2_p1;
  logic [4:0]          dest_p1;
  logic                wen_p1;

  alu_inst_dec u_dec (
    .inst    (in_inst),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .control (ctrl_p0),
    .src1    (src1_p0),
    .src2    (src2_p0),
    .dest    (dest_p0),
    .wen     (wen_p0),
    .ri      (ri_p0)
  );

  // p0 -> p1: accept when the output slot is empty or draining, never on flush
  assign in_ready  = ~flush & (~vld_p1 | out_ready);
  assign accept_p0 = in_valid & in_ready;

  // Output valid: flush dominates, then acceptance, then downstream consumption
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               vld_p1 <= 1'b0;
    else if (flush)            vld_p1 <= 1'b0;
    else if (accept_p0)        vld_p1 <= 1'b1;
    else if (out_ready)        vld_p1 <= 1'b0;
  end

  // Output payload loads only on acceptance so it holds steady while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_p1 <= '0;
      src1_p1 <= '0;
      src2_p1 <= '0;
      dest_p1 <= '0;
      wen_p1  <= 1'b0;
    end else if (accept_p0) begin
      ctrl_p1 <= ctrl_p0;
      src1_p1 <= src1_p0;
      src2_p1 <= src2_p0;
      dest_p1 <= dest_p0;
      wen_p1  <= wen_p0;
    end
  end

`ifdef ALU_DEC_RI_EN
  logic ri_p1;

  // Reserved-instruction flag travels with the rest of the payload
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        ri_p1 <= 1'b0;
    else if (accept_p0) ri_p1 <= ri_p0;
  end

  assign out_ri = ri_p1;
`else
  logic unused_ri;
  assign unused_ri = ri_p0;
`endif

  assign out_valid       = vld_p1;
  assign out_alu_control = ctrl_p1;
  assign out_alu_src1    = src1_p1;
  assign out_alu_src2    = src2_p1;
  assign out_dest        = dest_p1;
  assign out_wen         = wen_p1;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage. Honours ALU_DEC_RI_EN when defined.
module tb_alu_decode_stage;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_alu_control;
  logic [31:0] out_alu_src1;
  logic [31:0] out_alu_src2;
  logic [4:0]  out_dest;
  logic        out_wen;
`ifdef ALU_DEC_RI_EN
  logic        out_ri;
`endif

  int checks = 0;
  int errors = 0;

  alu_decode_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_inst         (in_inst),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_alu_control (out_alu_control),
    .out_alu_src1    (out_alu_src1),
    .out_alu_src2    (out_alu_src2),
    .out_dest        (out_dest),
`ifdef ALU_DEC_RI_EN
    .out_ri          (out_ri),
`endif
    .out_wen         (out_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [11:0] ctrl, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [4:0] dst, input logic wen);
    chk({tag, ".valid"}, 32'(out_valid), 32'h1);
    chk({tag, ".ctrl"},  32'(out_alu_control), 32'(ctrl));
    chk({tag, ".src1"},  out_alu_src1, s1);
    chk({tag, ".src2"},  out_alu_src2, s2);
    chk({tag, ".dest"},  32'(out_dest), 32'(dst));
    chk({tag, ".wen"},   32'(out_wen), 32'(wen));
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_inst   = 32'h0;
    rs_data   = 32'h0;
    rt_data   = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst.valid", 32'(out_valid), 32'h0);
    chk("rst.ctrl",  32'(out_alu_control), 32'h0);
    chk("rst.src1",  out_alu_src1, 32'h0);
    chk("rst.wen",   32'(out_wen), 32'h0);
    repeat (2) step();
    resetn = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'h1);

    // addu $3,$1,$2
    in_valid = 1'b1; in_inst = 32'h00221821; rs_data = 32'd5; rt_data = 32'd7;
    step();
    chk_out("addu", 12'h800, 32'd5, 32'd7, 5'd3, 1'b1);

    // sra $4,$2,3
    in_inst = 32'h000220C3; rs_data = 32'h00001234; rt_data = 32'h80000000;
    step();
    chk_out("sra", 12'h002, 32'd3, 32'h80000000, 5'd4, 1'b1);

    // addiu $5,$0,-1
    in_inst = 32'h2405FFFF; rs_data = 32'h0; rt_data = 32'h55;
    step();
    chk_out("addiu", 12'h800, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1);

    // andi $5,$0,0xFFFF
    in_inst = 32'h3005FFFF; rs_data = 32'h0;
    step();
    chk_out("andi", 12'h080, 32'h0, 32'h0000FFFF, 5'd5, 1'b1);

    // lui $7,0xABCD
    in_inst = 32'h3C07ABCD; rs_data = 32'hDEADBEEF;
    step();
    chk_out("lui", 12'h001, 32'h0, 32'h0000ABCD, 5'd7, 1'b1);

    // slt $0,$1,$2 : legal but dest 0 -> no write
    in_inst = 32'h0022002A; rs_data = 32'h3; rt_data = 32'h9;
    step();
    chk_out("slt_r0", 12'h200, 32'h3, 32'h9, 5'd0, 1'b0);

    // sllv $4,$3,$2 : variable shift uses rs_data
    in_inst = 32'h00432004; rs_data = 32'h11; rt_data = 32'h0F0F;
    step();
    chk_out("sllv", 12'h008, 32'h11, 32'h0F0F, 5'd4, 1'b1);

    // nor $3,$1,$2
    in_inst = 32'h00221827; rs_data = 32'hA; rt_data = 32'hB;
    step();
    chk_out("nor", 12'h040, 32'hA, 32'hB, 5'd3, 1'b1);

    // illegal opcode 0x3F
    in_inst = 32'hFC000000; rs_data = 32'h12345678; rt_data = 32'h9ABCDEF0;
    step();
    chk_out("ill_op", 12'h000, 32'h0, 32'h0, 5'd0, 1'b0);
`ifdef ALU_DEC_RI_EN
    chk("ill_op.ri", 32'(out_ri), 32'h1);
`endif

    // illegal SPECIAL funct 0x01
    in_inst = 32'h00221801;
    step();
    chk_out("ill_fn", 12'h000, 32'h0, 32'h0, 5'd0, 1'b0);

    // back to a legal word, then stall it for three cycles
    in_inst = 32'h00221821; rs_data = 32'd5; rt_data = 32'd7;
    step();
    chk_out("pre_stall", 12'h800, 32'd5, 32'd7, 5'd3, 1'b1);
`ifdef ALU_DEC_RI_EN
    chk("legal.ri", 32'(out_ri), 32'h0);
`endif
    out_ready = 1'b0;
    in_inst = 32'h00432026; rs_data = 32'h21; rt_data = 32'h42;  // xor $4,$2,$3
    #1;
    chk("stall.in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall_hold", 12'h800, 32'd5, 32'd7, 5'd3, 1'b1);
      chk("stall.in_ready_hold", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'h1);
    step();
    chk_out("xor_after_stall", 12'h010, 32'h21, 32'h42, 5'd4, 1'b1);

    // drain
    in_valid = 1'b0;
    step();
    chk("drain.valid", 32'(out_valid), 32'h0);

    // flush with a held word and a new word offered
    in_valid = 1'b1; in_inst = 32'h00221821; rs_data = 32'd1; rt_data = 32'd2;
    step();
    chk("pre_flush.valid", 32'(out_valid), 32'h1);
    flush = 1'b1; out_ready = 1'b0; in_inst = 32'h3C07ABCD;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'h0);
    step();
    chk("flush.valid", 32'(out_valid), 32'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("post_flush.valid", 32'(out_valid), 32'h0);

    // reset asserted in the middle of a stall
    in_valid = 1'b1; in_inst = 32'h3C07ABCD; out_ready = 1'b0;
    step();
    chk_out("pre_reset", 12'h001, 32'h0, 32'h0000ABCD, 5'd7, 1'b1);
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst.valid", 32'(out_valid), 32'h0);
    chk("midrst.ctrl",  32'(out_alu_control), 32'h0);
    chk("midrst.src1",  out_alu_src1, 32'h0);
    chk("midrst.src2",  out_alu_src2, 32'h0);
    chk("midrst.dest",  32'(out_dest), 32'h0);
    chk("midrst.wen",   32'(out_wen), 32'h0);
`ifdef ALU_DEC_RI_EN
    chk("midrst.ri", 32'(out_ri), 32'h0);
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    resetn = 1'b1;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
